// File: rtl/de1_soc_pio_pkg.sv
// Shared constants and types for the de1_soc_pio_in input port.
package de1_soc_pio_pkg;

  localparam int unsigned PIO_BUS_W  = 32;
  localparam int unsigned PIO_ADDR_W = 2;

  localparam logic [PIO_ADDR_W-1:0] PIO_REG_DATA = 2'd0;
  localparam logic [PIO_ADDR_W-1:0] PIO_REG_RAW  = 2'd1;
  localparam logic [PIO_ADDR_W-1:0] PIO_REG_MASK = 2'd2;
  localparam logic [PIO_ADDR_W-1:0] PIO_REG_EDGE = 2'd3;

  localparam int unsigned PIO_IRQ_LEVEL = 0;
  localparam int unsigned PIO_IRQ_EDGE  = 1;

  localparam int unsigned PIO_EDGE_RISE = 0;
  localparam int unsigned PIO_EDGE_FALL = 1;
  localparam int unsigned PIO_EDGE_ANY  = 2;

  typedef struct packed {
    logic                  valid;
    logic [PIO_ADDR_W-1:0] addr;
    logic [PIO_BUS_W-1:0]  data;
  } pio_wr_t;

  // Counter width for a debounce threshold; never narrower than one bit.
  function automatic int unsigned pio_cnt_width(input int unsigned cycles);
    if (cycles > 1) return unsigned'($clog2(cycles));
    return 1;
  endfunction

endpackage

// File: rtl/de1_soc_pio_debounce.sv
// One input bit: two-flop synchroniser followed by an optional stability filter.
// Filter is built only when DE1_SOC_PIO_IN_DEBOUNCE_EN is defined.
module de1_soc_pio_debounce
  import de1_soc_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic sync_in,
  output logic data_q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta    <= 1'b0;
      sync_in <= 1'b0;
    end else begin
      meta    <= in_bit;
      sync_in <= meta;
    end
  end

`ifdef DE1_SOC_PIO_IN_DEBOUNCE_EN
  localparam int unsigned CNT_W = pio_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count mismatch cycles; accept on the last one, so cnt never passes CNT_LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      data_q <= 1'b0;
    end else if (sync_in == data_q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      data_q <= sync_in;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  // Threshold has no meaning without the counter.
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= 1'b0;
    else          data_q <= sync_in;
  end
`endif

endmodule

// File: rtl/de1_soc_pio_in.sv
// Avalon-MM input port: per-bit sync/debounce, edge capture (W1C) and maskable irq.
// Debounce counters are present only with DE1_SOC_PIO_IN_DEBOUNCE_EN defined.
module de1_soc_pio_in
  import de1_soc_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned IRQ_MODE        = 0,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  irq,
  input  logic [WIDTH-1:0]      in_port
);

  localparam int unsigned DB_CYCLES = (DEBOUNCE_CYCLES == 0) ? 1 : DEBOUNCE_CYCLES;

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_next;
  pio_wr_t          wr;
  logic             unused_wr_data;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    de1_soc_pio_debounce #(
      .DEBOUNCE_CYCLES(DB_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .in_bit (in_port[g]),
      .sync_in(sync_in[g]),
      .data_q (data_q[g])
    );
  end

  always_comb begin
    wr.valid = chipselect & ~write_n;
    wr.addr  = address;
    wr.data  = writedata;
  end

  // Bits above WIDTH are not stored anywhere.
  assign unused_wr_data = ^wr.data;

  // Edge selection and W1C decode.
  always_comb begin
    edge_hit = data_q & ~data_d;
    if (EDGE_TYPE == PIO_EDGE_FALL)     edge_hit = ~data_q & data_d;
    else if (EDGE_TYPE == PIO_EDGE_ANY) edge_hit = data_q ^ data_d;
    edge_clr = '0;
    if (wr.valid && wr.addr == PIO_REG_EDGE) edge_clr = wr.data[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_d   <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      data_d   <= data_q;
      edge_cap <= (edge_cap & ~edge_clr) | edge_hit;
      if (wr.valid && wr.addr == PIO_REG_MASK) irq_mask <= wr.data[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      PIO_REG_DATA: rd_next = 32'(data_q);
      PIO_REG_RAW:  rd_next = 32'(sync_in);
      PIO_REG_MASK: rd_next = 32'(irq_mask);
      PIO_REG_EDGE: rd_next = 32'(edge_cap);
      default:      rd_next = '0;
    endcase
  end

  // Reads are unstrobed: readdata tracks address every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = (IRQ_MODE == PIO_IRQ_EDGE) ? |(edge_cap & irq_mask) : |(data_q & irq_mask);

endmodule
